// File: rtl/wb_master_pkg.sv
// Shared Wishbone master definitions: FSM state encodings and bus opcode values.
// The slave blocks use the same values.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WDAT = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    localparam logic WB_OP_READ  = 1'b0;
    localparam logic WB_OP_WRITE = 1'b1;

    function automatic int unsigned tout_width(input int unsigned tout);
        return $clog2(tout);
    endfunction

endpackage

// File: rtl/wb_tout_cnt.sv
// Ack-timeout counter: clearable, enabled per cycle, flags the terminal count TOUT-1.
module wb_tout_cnt
    import wb_master_pkg::*;
#(
    parameter int unsigned TOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CW = tout_width(TOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tc = (cnt == TC_VAL);

endmodule

// File: rtl/wb_master.sv
// Single-outstanding Wishbone master: latches a local request, drives one bus cycle,
// and returns a registered one-cycle completion pulse with read data or timeout error.
module wb_master
    import wb_master_pkg::*;
#(
    parameter int unsigned ASIZE  = 2,
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned TOUT   = 16,
    parameter int unsigned RD_DLY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [ASIZE-1:0] i_addr,
    input  logic             i_we,
    input  logic [DSIZE-1:0] i_wdata,
    output logic             o_ready,
    output logic [DSIZE-1:0] o_rdata,
    output logic             o_err,
    output logic [ASIZE-1:0] o_adr,
    output logic             o_we,
    output logic [DSIZE-1:0] o_dat,
    output logic             o_stb,
    input  logic             i_ack,
    input  logic [DSIZE-1:0] i_dat
);

    wb_state_e state;
    logic      cnt_clr;
    logic      cnt_en;
    logic      cnt_tc;

    assign cnt_clr = (state == ST_IDLE) && i_valid;
    assign cnt_en  = (state == ST_REQ) && !i_ack;

    wb_tout_cnt #(
        .TOUT(TOUT)
    ) u_tout (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (cnt_clr),
        .i_en   (cnt_en),
        .o_tc   (cnt_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            o_stb   <= 1'b0;
            o_ready <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;
            o_adr   <= '0;
            o_we    <= 1'b0;
            o_dat   <= '0;
        end else begin
            o_ready <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        o_adr <= i_addr;
                        o_we  <= i_we;
                        o_dat <= i_wdata;
                        o_stb <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (i_ack) begin
                        o_stb <= 1'b0;
                        if (o_we == WB_OP_READ && RD_DLY != 0) begin
                            state <= ST_WDAT;
                        end else begin
                            if (o_we == WB_OP_READ) begin
                                o_rdata <= i_dat;
                            end
                            o_ready <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end else if (cnt_tc) begin
                        o_stb   <= 1'b0;
                        o_err   <= 1'b1;
                        o_ready <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_WDAT: begin
                    o_rdata <= i_dat;
                    o_ready <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    o_err <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: directed vector table, randomized transactions against a
// transaction-level timing model, and a mid-transaction reset sequence.
module tb_wb_master;

    localparam int ASIZE  = 2;
    localparam int DSIZE  = 8;
    localparam int TOUT   = 16;
    localparam int RD_DLY = 1;
    localparam int NOACK  = 99;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic [ASIZE-1:0] i_addr;
    logic             i_we;
    logic [DSIZE-1:0] i_wdata;
    logic             o_ready;
    logic [DSIZE-1:0] o_rdata;
    logic             o_err;
    logic [ASIZE-1:0] o_adr;
    logic             o_we;
    logic [DSIZE-1:0] o_dat;
    logic             o_stb;
    logic             i_ack;
    logic [DSIZE-1:0] i_dat;

    int checks   = 0;
    int failures = 0;

    logic [DSIZE-1:0] slave_mem [4];
    logic [DSIZE-1:0] model_rdata;

    wb_master #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE),
        .TOUT  (TOUT),
        .RD_DLY(RD_DLY)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .i_addr (i_addr),
        .i_we   (i_we),
        .i_wdata(i_wdata),
        .o_ready(o_ready),
        .o_rdata(o_rdata),
        .o_err  (o_err),
        .o_adr  (o_adr),
        .o_we   (o_we),
        .o_dat  (o_dat),
        .o_stb  (o_stb),
        .i_ack  (i_ack),
        .i_dat  (i_dat)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit               we;
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] wdata;
        int               lat;
        logic [DSIZE-1:0] rdat;
        bit               keep;
        int               exp_rc;
        bit               exp_err;
        logic [DSIZE-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0h required=%0h t=%0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One transaction starting in IDLE at cycle 0. lat = cycles after stb rises before ack
    // (>= TOUT means the slave never acks). Returns at the IDLE cycle after RESP.
    task automatic run_txn(input string tag, input bit we, input logic [ASIZE-1:0] addr,
                           input logic [DSIZE-1:0] wdata, input int lat,
                           input logic [DSIZE-1:0] rdat, input bit keep, input int exp_rc,
                           input bit exp_err, input logic [DSIZE-1:0] exp_rdata);
        bit acked;
        int ack_cyc;
        int stb_last;
        acked    = (lat < TOUT);
        ack_cyc  = 1 + lat;
        stb_last = acked ? ack_cyc : TOUT;
        for (int c = 0; c <= exp_rc; c++) begin
            check(tag, "stb", 32'(o_stb), 32'(c >= 1 && c <= stb_last));
            check(tag, "ready", 32'(o_ready), 32'(c == exp_rc));
            if (c == exp_rc) begin
                check(tag, "err", 32'(o_err), 32'(exp_err));
                check(tag, "rdata", 32'(o_rdata), 32'(exp_rdata));
            end
            if (c >= 1) begin
                check(tag, "hold", 32'({o_adr, o_we, o_dat}), 32'({addr, we, wdata}));
            end
            i_valid = (c == 0) || keep;
            if (c == 0) begin
                i_addr  = addr;
                i_we    = we;
                i_wdata = wdata;
            end else begin
                i_addr  = ASIZE'($urandom);
                i_we    = 1'($urandom);
                i_wdata = DSIZE'($urandom);
            end
            i_ack = acked && (c == ack_cyc);
            i_dat = (acked && c == ack_cyc + RD_DLY) ? rdat : ~rdat;
            if (i_ack && o_stb && o_we) slave_mem[o_adr] = o_dat;
            tick();
        end
        i_ack = 1'b0;
        if (we && acked) check(tag, "slave_mem", 32'(slave_mem[addr]), 32'(wdata));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               we;
        bit               keep;
        bit               acked;
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] wdata;
        logic [DSIZE-1:0] rdat;
        logic [DSIZE-1:0] erd;
        int               lat;
        int               erc;
        int               r;

        vecs[0] = '{1'b1, 2'd1, 8'hA5, 1,     8'h00, 1'b0, 3,  1'b0, 8'h00};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 1,     8'h3C, 1'b0, 4,  1'b0, 8'h3C};
        vecs[2] = '{1'b0, 2'd3, 8'h00, NOACK, 8'h77, 1'b0, 17, 1'b1, 8'h3C};
        vecs[3] = '{1'b1, 2'd0, 8'h5A, 15,    8'h00, 1'b0, 17, 1'b0, 8'h3C};
        vecs[4] = '{1'b0, 2'd1, 8'h00, 15,    8'hC3, 1'b0, 18, 1'b0, 8'hC3};
        vecs[5] = '{1'b0, 2'd0, 8'h00, 0,     8'h11, 1'b0, 3,  1'b0, 8'h11};
        vecs[6] = '{1'b1, 2'd1, 8'h01, 0,     8'h00, 1'b1, 2,  1'b0, 8'h11};
        vecs[7] = '{1'b1, 2'd2, 8'h02, 2,     8'h00, 1'b1, 4,  1'b0, 8'h11};
        vecs[8] = '{1'b1, 2'd3, 8'h03, 1,     8'h00, 1'b0, 3,  1'b0, 8'h11};
        vecs[9] = '{1'b1, 2'd2, 8'hEE, NOACK, 8'h00, 1'b0, 17, 1'b1, 8'h11};

        for (int i = 0; i < 4; i++) slave_mem[i] = '0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_addr  = '0;
        i_we    = 1'b0;
        i_wdata = '0;
        i_ack   = 1'b0;
        i_dat   = '0;
        tick();
        tick();
        check("reset", "stb", 32'(o_stb), 32'd0);
        check("reset", "ready", 32'(o_ready), 32'd0);
        check("reset", "err", 32'(o_err), 32'd0);
        check("reset", "rdata", 32'(o_rdata), 32'd0);
        check("reset", "bus", 32'({o_adr, o_we, o_dat}), 32'd0);
        i_rst_n = 1'b1;
        tick();
        model_rdata = '0;

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].lat, vecs[i].rdat, vecs[i].keep, vecs[i].exp_rc,
                    vecs[i].exp_err, vecs[i].exp_rdata);
            model_rdata = vecs[i].exp_rdata;
        end

        for (int k = 0; k < 30; k++) begin
            we    = 1'($urandom);
            addr  = ASIZE'($urandom);
            wdata = DSIZE'($urandom);
            rdat  = DSIZE'($urandom);
            r     = $urandom_range(0, 9);
            lat   = (r == 0) ? NOACK : (r == 1) ? TOUT - 1 : $urandom_range(0, 5);
            acked = (lat < TOUT);
            erc   = !acked ? TOUT + 1 : (!we && RD_DLY != 0) ? lat + 3 : lat + 2;
            erd   = (!we && acked) ? rdat : model_rdata;
            keep  = (k != 29) && ($urandom_range(0, 1) == 1);
            run_txn($sformatf("rnd%0d", k), we, addr, wdata, lat, rdat, keep, erc,
                    !acked, erd);
            model_rdata = erd;
            if (!keep) repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during the second REQ cycle of a read.
        i_valid = 1'b1;
        i_we    = 1'b0;
        i_addr  = 2'd2;
        tick();
        i_valid = 1'b0;
        check("rst_mid", "stb_c1", 32'(o_stb), 32'd1);
        tick();
        i_rst_n = 1'b0;
        #1;
        check("rst_mid", "stb", 32'(o_stb), 32'd0);
        check("rst_mid", "ready", 32'(o_ready), 32'd0);
        check("rst_mid", "bus", 32'({o_adr, o_we, o_dat}), 32'd0);
        check("rst_mid", "rdata", 32'(o_rdata), 32'd0);
        repeat (3) begin
            tick();
            check("rst_mid", "no_ready", 32'(o_ready), 32'd0);
        end
        i_rst_n = 1'b1;
        model_rdata = '0;
        tick();
        check("rst_mid", "idle_ready", 32'(o_ready), 32'd0);
        run_txn("post_rst", 1'b0, 2'd2, 8'h00, 1, 8'h96, 1'b0, 4, 1'b0, 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
